serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial two's-complement subtractor computing DIFF = A − B − BIN, one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop. It pairs with the adder cells already in the datapath library. It is the area-minimal subtract path for ALU experiments where latency is acceptable. Operands load in parallel on a START pulse, and results are presented in parallel with a one-cycle DONE strobe.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- CLK  input  1  clock; all state updates on rising edge
- RST  input  1  synchronous, active-high reset
- START  input  1  load request; sampled only when not BUSY
- A  input  WIDTH  minuend, sampled on accepted START
- B  input  WIDTH  subtrahend, sampled on accepted START
- BIN  input  1  borrow-in, sampled on accepted START
- BUSY  output  1  high while bits are being processed
- DONE  output  1  one-cycle strobe: result registers just updated
- DIFF  output  WIDTH  A − B − BIN modulo 2^WIDTH
- BOUT  output  1  borrow-out (1 when unsigned A < B + BIN)
- OVF  output  1  signed overflow of the subtraction
- ZERO  output  1  DIFF == 0

## Operation
- Reset:
  - Applies on any edge with RST=1, overriding everything, including START.
  - Forces state IDLE and clears BUSY, DONE, DIFF, BOUT, OVF and ZERO to 0.
  - Clears the internal shift registers, the borrow flop and the counter.
- States:
  - IDLE → SHIFT on START.
  - SHIFT → FIN after WIDTH bit-cycles.
  - FIN → SHIFT if START, else IDLE.
- Accepting START (in IDLE or FIN):
  - Latch A, B into right-shift registers.
  - Set borrow flop = BIN and bit counter = 0.
  - Enter SHIFT. START in SHIFT is ignored (no queueing).
- Each SHIFT cycle, with a = A_sh[0], b = B_sh[0], br = borrow flop:
  - Difference bit d = a ^ b ^ br, shifted into the MSB of the internal result shift register.
  - Next borrow = (~a & b) | (~(a ^ b) & br).
  - A_sh and B_sh shift right one bit; the counter increments.
  - A_sh[WIDTH−1] and B_sh[WIDTH−1] are captured internally as operand signs at load.
- On the cycle the counter reaches WIDTH−1, the edge:
  - Writes DIFF from the completed shift register (including the final bit).
  - Writes BOUT = final borrow.
  - Writes OVF = (signA ≠ signB) & (DIFF[WIDTH−1] ≠ signA).
  - Writes ZERO = (DIFF == 0).
  - Moves the FSM to FIN.
- Result outputs DIFF/BOUT/OVF/ZERO change only at completion or on reset. Between operations they hold the last result; they never show partial values.
- BUSY = 1 exactly in SHIFT. DONE = 1 exactly in FIN.

## Timing
- Handshake: START accepted at edge 0 → BUSY high from cycle 1 through cycle WIDTH.
- DONE and the new results are visible in cycle WIDTH+1 (latency WIDTH+1 edges; 9 for WIDTH=8).
- Back-to-back throughput: START held high gives one result every WIDTH+1 cycles. START in the FIN cycle is accepted, so DONE never stays high two consecutive cycles.
- A/B/BIN need to be stable only at the accepting edge; later changes have no effect.
- RST mid-SHIFT: the operation is abandoned, no DONE is produced, and outputs read 0 the next cycle.
- Simultaneous RST and START: reset wins, START is discarded.

## Test plan
- WIDTH=8, A=0x05, B=0x03, BIN=0, START at cycle 0:
  - BUSY cycles 1–8.
  - Cycle 9: DONE=1, DIFF=0x02, BOUT=0, OVF=0, ZERO=0.
  - Cycle 10: DONE=0 and outputs unchanged.
- A=0x03, B=0x05 → DIFF=0xFE, BOUT=1, OVF=0.
- A=0x80, B=0x01 → DIFF=0x7F, OVF=1, BOUT=0.
- A=0x7F, B=0xFF → DIFF=0x80, OVF=1, BOUT=1.
- A=0x2A, B=0x2A, BIN=0 → DIFF=0x00, ZERO=1, BOUT=0.
- A=0x00, B=0x00, BIN=1 → DIFF=0xFF, BOUT=1, ZERO=0.
- Change A/B at cycle 3 and pulse START at cycle 4 of a running 0x05−0x03:
  - Result is still 0x02 at cycle 9.
  - No second operation starts.
- START held high continuously:
  - DONE at cycles 9 and 18.
  - Operand values present at cycles 0 and 9 are used respectively.
- Assert RST at cycle 5 of an operation:
  - Cycle 6: BUSY=0, all outputs 0.
  - No DONE follows.
  - A fresh START at cycle 7 completes at cycle 16.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: DIFF = A - B - BIN, LSB first,
// one full-subtractor cell plus a borrow flop, parallel load and result.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_bin,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_bout,
  output logic             o_ovf,
  output logic             o_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_FIN
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-2:0] r_d_sh;
  logic [CW-1:0]    r_cnt;
  logic             r_br;
  logic             r_sign_a;
  logic             r_sign_b;

  logic             w_a;
  logic             w_b;
  logic             w_d;
  logic             w_br_nxt;
  logic [WIDTH-1:0] w_res;
  logic             w_last;
  logic             w_accept;
  logic             w_ovf;

  assign w_a      = r_a_sh[0];
  assign w_b      = r_b_sh[0];
  assign w_d      = w_a ^ w_b ^ r_br;
  assign w_br_nxt = (~w_a & w_b) | (~(w_a ^ w_b) & r_br);
  assign w_res    = {w_d, r_d_sh};
  assign w_last   = (r_cnt == CW'(WIDTH - 1));
  assign w_accept = i_start & (r_state != S_SHIFT);
  assign w_ovf    = (r_sign_a ^ r_sign_b) & (w_d ^ r_sign_a);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_d_sh   <= '0;
      r_cnt    <= '0;
      r_br     <= 1'b0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_diff   <= '0;
      o_bout   <= 1'b0;
      o_ovf    <= 1'b0;
      o_zero   <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (w_accept) begin
        r_a_sh   <= i_a;
        r_b_sh   <= i_b;
        r_br     <= i_bin;
        r_cnt    <= '0;
        r_sign_a <= i_a[WIDTH-1];
        r_sign_b <= i_b[WIDTH-1];
        r_state  <= S_SHIFT;
        o_busy   <= 1'b1;
      end else begin
        case (r_state)
          S_SHIFT: begin
            r_a_sh <= {1'b0, r_a_sh[WIDTH-1:1]};
            r_b_sh <= {1'b0, r_b_sh[WIDTH-1:1]};
            r_d_sh <= w_res[WIDTH-1:1];
            r_br   <= w_br_nxt;
            r_cnt  <= r_cnt + CW'(1);
            // final bit goes straight to DIFF so no partial value is visible
            if (w_last) begin
              o_diff  <= w_res;
              o_bout  <= w_br_nxt;
              o_ovf   <= w_ovf;
              o_zero  <= (w_res == '0);
              o_busy  <= 1'b0;
              o_done  <= 1'b1;
              r_state <= S_FIN;
            end
          end
          S_FIN:   r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: directed, timing and random
// operations checked against an arithmetic reference model.
module tb_serial_subtractor;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
    logic         zero;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;
  logic         zero;

  int   n_chk  = 0;
  int   n_err  = 0;
  int   n_done = 0;
  exp_t sb[$];

  serial_subtractor #(.WIDTH(W)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start),
    .i_a     (a),
    .i_b     (b),
    .i_bin   (bin),
    .o_busy  (busy),
    .o_done  (done),
    .o_diff  (diff),
    .o_bout  (bout),
    .o_ovf   (ovf),
    .o_zero  (zero)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(logic [W-1:0] x, logic [W-1:0] y,
                                 logic bi);
    exp_t e;
    int   d;
    d      = int'(x) - int'(y) - int'(bi);
    e.diff = d[W-1:0];
    e.bout = (d < 0);
    e.ovf  = (x[W-1] != y[W-1]) && (e.diff[W-1] != x[W-1]);
    e.zero = (e.diff == '0);
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp,
               $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      n_done++;
      if (sb.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 expected none at %0t",
                 $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("diff", diff, e.diff);
        chk("bout", bout, e.bout);
        chk("ovf", ovf, e.ovf);
        chk("zero", zero, e.zero);
      end
    end
  end

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic bi);
    exp_t e;
    a     = x;
    b     = y;
    bin   = bi;
    start = 1'b1;
    e     = model(x, y, bi);
    sb.push_back(e);
    tick();
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    bin   = 1'($urandom);
    for (int c = 1; c <= W; c++) begin
      chk("busy_shift", busy, 1);
      chk("done_shift", done, 0);
      tick();
    end
    chk("done_fin", done, 1);
    chk("busy_fin", busy, 0);
    tick();
    chk("done_after", done, 0);
    chk("diff_hold", diff, e.diff);
    chk("bout_hold", bout, e.bout);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    bin   = 1'b0;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_flags", {bout, ovf, zero}, 0);
    rst = 1'b0;
    tick();

    run_op(8'h05, 8'h03, 1'b0);
    run_op(8'h03, 8'h05, 1'b0);
    run_op(8'h80, 8'h01, 1'b0);
    run_op(8'h7F, 8'hFF, 1'b0);
    run_op(8'h2A, 8'h2A, 1'b0);
    run_op(8'h00, 8'h00, 1'b1);

    // operands change mid-operation and START is pulsed while busy
    a     = 8'h05;
    b     = 8'h03;
    bin   = 1'b0;
    start = 1'b1;
    sb.push_back(model(8'h05, 8'h03, 1'b0));
    tick();
    start = 1'b0;
    tick();
    tick();
    a = 8'hC3;
    b = 8'h11;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 5; c < 9; c++) tick();
    chk("mid_done", done, 1);
    tick();
    chk("mid_no_restart", busy, 0);
    tick();
    chk("mid_no_restart2", busy, 0);

    // START held high: back-to-back operations
    a     = 8'h9C;
    b     = 8'h21;
    bin   = 1'b1;
    start = 1'b1;
    sb.push_back(model(8'h9C, 8'h21, 1'b1));
    tick();
    a   = 8'h10;
    b   = 8'h7E;
    bin = 1'b0;
    sb.push_back(model(8'h10, 8'h7E, 1'b0));
    for (int c = 1; c < 9; c++) tick();
    chk("b2b_done1", done, 1);
    tick();
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    chk("b2b_busy2", busy, 1);
    chk("b2b_done_drop", done, 0);
    for (int c = 10; c < 18; c++) begin
      chk("b2b_no_early", done, 0);
      tick();
    end
    chk("b2b_done2", done, 1);
    tick();
    chk("b2b_idle", busy, 0);
    chk("b2b_done_end", done, 0);

    // reset in the middle of an operation
    a     = 8'hF0;
    b     = 8'h0F;
    bin   = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 5; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_diff", diff, 0);
    chk("abort_flags", {bout, ovf, zero}, 0);
    d0 = n_done;
    tick();
    a     = 8'h44;
    b     = 8'h45;
    bin   = 1'b0;
    start = 1'b1;
    sb.push_back(model(8'h44, 8'h45, 1'b0));
    tick();
    start = 1'b0;
    for (int c = 8; c < 16; c++) begin
      chk("abort_no_done", done, 0);
      tick();
    end
    chk("fresh_done", done, 1);
    tick();
    chk("fresh_done_count", n_done, d0 + 1);

    // reset and start together: reset wins
    rst   = 1'b1;
    start = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    chk("rst_start_busy", busy, 0);
    tick();
    chk("rst_start_busy2", busy, 0);
    chk("rst_start_done", done, 0);

    for (int i = 0; i < 30; i++) begin
      int gap;
      run_op(W'($urandom), W'($urandom), 1'($urandom));
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) tick();
    end

    tick();
    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
